decode_stage: RTL and testbench

Registered, parametrised instruction decode stage between fetch and execute. Decodes RV32I/RV64I base opcodes, including OP-32/OP-IMM-32, SYSTEM and MISC-MEM, and flags illegal encodings. Carries instruction and PC with valid/ready handshakes on both sides and supports a synchronous pipeline flush. Control encodings are the `core_pkg` enums: aluop `Add`/`Funct`/`Branch`, jump `JmpNone`/`Jal`/`Jalr`, mem `MemNone`/`MemLoad`/`MemStore`.

---
 rtl/decode_stage.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I instruction decode stage with valid/ready handshakes and flush.
// Define DECODE_SKID_BUF_EN to add a one-entry skid buffer and a registered ready_o.

package core_pkg;
    parameter int unsigned Xlen = 64;

    typedef enum logic [1:0] { Add = 2'd0, Funct = 2'd1, Branch = 2'd2 } aluop_e;
    typedef enum logic [1:0] { JmpNone = 2'd0, Jal = 2'd1, Jalr = 2'd2 } jump_e;
    typedef enum logic [1:0] { MemNone = 2'd0, MemLoad = 2'd1, MemStore = 2'd2 } mem_e;
endpackage

module decode_stage
    import core_pkg::*;
#(
    parameter int unsigned Xlen = core_pkg::Xlen
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    input  logic [Xlen-1:0] pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [Xlen-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [Xlen-1:0] imm_o,
    output logic [1:0]      aluop_o,
    output logic            alu_use_imm_o,
    output logic            reg_wb_o,
    output logic            reg_lui_o,
    output logic            is_auipc_o,
    output logic            branch_o,
    output logic            mem_to_reg_o,
    output logic [1:0]      jump_o,
    output logic [1:0]      mem_type_o,
    output logic            word_op_o,
    output logic            ecall_o,
    output logic            ebreak_o,
    output logic            illegal_o
);

    if (Xlen != 32 && Xlen != 64) begin : g_bad_xlen
        $error("decode_stage: Xlen must be 32 or 64");
    end

    localparam bit Rv64 = (Xlen == 64);

    localparam logic [6:0] OpcLoad     = 7'b0000011;
    localparam logic [6:0] OpcMiscMem  = 7'b0001111;
    localparam logic [6:0] OpcOpImm    = 7'b0010011;
    localparam logic [6:0] OpcAuipc    = 7'b0010111;
    localparam logic [6:0] OpcOpImm32  = 7'b0011011;
    localparam logic [6:0] OpcStore    = 7'b0100011;
    localparam logic [6:0] OpcOp       = 7'b0110011;
    localparam logic [6:0] OpcLui      = 7'b0110111;
    localparam logic [6:0] OpcOp32     = 7'b0111011;
    localparam logic [6:0] OpcBranch   = 7'b1100011;
    localparam logic [6:0] OpcJalr     = 7'b1100111;
    localparam logic [6:0] OpcJal      = 7'b1101111;
    localparam logic [6:0] OpcSystem   = 7'b1110011;

    typedef struct packed {
        logic [Xlen-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [Xlen-1:0] imm;
        aluop_e          aluop;
        logic            alu_use_imm;
        logic            reg_wb;
        logic            reg_lui;
        logic            is_auipc;
        logic            branch;
        logic            mem_to_reg;
        jump_e           jump;
        mem_e            mem_type;
        logic            word_op;
        logic            ecall;
        logic            ebreak;
        logic            illegal;
    } bundle_t;

    logic [Xlen-1:0] imm_i_fmt, imm_s_fmt, imm_b_fmt, imm_u_fmt, imm_j_fmt;
    logic [2:0]      funct3;
    logic            ill;
    bundle_t         dec;

    // Size casts of signed operands sign-extend from instr[31] to Xlen.
    assign imm_i_fmt = Xlen'($signed(instr_i[31:20]));
    assign imm_s_fmt = Xlen'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b_fmt = Xlen'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_u_fmt = Xlen'($signed({instr_i[31:12], 12'b0}));
    assign imm_j_fmt = Xlen'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
    assign funct3    = instr_i[14:12];

    always_comb begin
        // NOTE: every field gets a default first, so no path through the case can infer a latch.
        dec       = '0;
        ill       = 1'b0;
        dec.pc    = pc_i;
        dec.instr = instr_i;
        dec.rd    = instr_i[11:7];
        dec.rs1   = instr_i[19:15];
        dec.rs2   = instr_i[24:20];

        case (instr_i[6:0])
            OpcOp: begin
                dec.aluop  = Funct;
                dec.reg_wb = 1'b1;
            end
            OpcOpImm: begin
                dec.aluop       = Funct;
                dec.reg_wb      = 1'b1;
                dec.alu_use_imm = 1'b1;
                dec.imm         = imm_i_fmt;
            end
            OpcOp32: begin
                dec.aluop   = Funct;
                dec.reg_wb  = 1'b1;
                dec.word_op = 1'b1;
                ill         = !Rv64;
            end
            OpcOpImm32: begin
                dec.aluop       = Funct;
                dec.reg_wb      = 1'b1;
                dec.alu_use_imm = 1'b1;
                dec.imm         = imm_i_fmt;
                dec.word_op     = 1'b1;
                ill             = !Rv64;
            end
            OpcLoad: begin
                dec.mem_type   = MemLoad;
                dec.mem_to_reg = 1'b1;
                dec.reg_wb     = 1'b1;
                dec.imm        = imm_i_fmt;
                ill = (funct3 == 3'b111) || (!Rv64 && (funct3 == 3'b011 || funct3 == 3'b110));
            end
            OpcStore: begin
                dec.mem_type = MemStore;
                dec.imm      = imm_s_fmt;
                ill = funct3[2] || (!Rv64 && funct3 == 3'b011);
            end
            OpcBranch: begin
                dec.branch = 1'b1;
                dec.aluop  = Branch;
                dec.imm    = imm_b_fmt;
                ill = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpcJal: begin
                dec.reg_wb = 1'b1;
                dec.jump   = Jal;
                dec.imm    = imm_j_fmt;
            end
            OpcJalr: begin
                dec.reg_wb      = 1'b1;
                dec.jump        = Jalr;
                dec.imm         = imm_i_fmt;
                dec.alu_use_imm = 1'b1;
                ill             = (funct3 != 3'b000);
            end
            OpcLui: begin
                dec.reg_lui     = 1'b1;
                dec.reg_wb      = 1'b1;
                dec.imm         = imm_u_fmt;
                dec.alu_use_imm = 1'b1;
            end
            OpcAuipc: begin
                dec.is_auipc    = 1'b1;
                dec.reg_wb      = 1'b1;
                dec.imm         = imm_u_fmt;
                dec.alu_use_imm = 1'b1;
            end
            OpcMiscMem: ;
            OpcSystem: begin
                if (instr_i == 32'h0000_0073)      dec.ecall  = 1'b1;
                else if (instr_i == 32'h0010_0073) dec.ebreak = 1'b1;
                else                               ill        = 1'b1;
            end
            default: ill = 1'b1;
        endcase

        if (instr_i[1:0] != 2'b11) ill = 1'b1;

        // An illegal instruction must not write state or redirect; pc/instr still travel for the trap.
        if (ill) begin
            dec.reg_wb     = 1'b0;
            dec.branch     = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.word_op    = 1'b0;
            dec.ecall      = 1'b0;
            dec.ebreak     = 1'b0;
            dec.jump       = JmpNone;
            dec.mem_type   = MemNone;
            dec.imm        = '0;
        end
        dec.illegal = ill;
    end

    bundle_t out_q, out_d;
    logic    in_xfer, out_xfer;

    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

`ifdef DECODE_SKID_BUF_EN
    typedef enum logic [1:0] { Empty = 2'd0, One = 2'd1, Two = 2'd2 } state_e;

    state_e  state_q, state_d;
    bundle_t skid_q, skid_d;
    logic    ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = Empty;
        end else begin
            case (state_q)
                Empty: begin
                    if (in_xfer) begin
                        out_d   = dec;
                        state_d = One;
                    end
                end
                One: begin
                    if (in_xfer && out_xfer) begin
                        out_d = dec;
                    end else if (in_xfer) begin
                        skid_d  = dec;
                        state_d = Two;
                    end else if (out_xfer) begin
                        state_d = Empty;
                    end
                end
                Two: begin
                    if (out_xfer) begin
                        out_d   = skid_q;
                        state_d = One;
                    end
                end
                default: state_d = Empty;
            endcase
        end
        ready_d = (state_d != Two);
    end

    // NOTE: payload flops are reset as well, because outputs must read 0 straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Empty;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign valid_o = (state_q != Empty);
    assign ready_o = ready_q;
`else
    logic valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_xfer) begin
            out_d   = dec;
            valid_d = 1'b1;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: payload flops are reset as well, because outputs must read 0 straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign valid_o = valid_q;
    assign ready_o = !valid_q || ready_i;
`endif

    assign pc_o          = out_q.pc;
    assign instr_o       = out_q.instr;
    assign rd_o          = out_q.rd;
    assign rs1_o         = out_q.rs1;
    assign rs2_o         = out_q.rs2;
    assign imm_o         = out_q.imm;
    assign aluop_o       = out_q.aluop;
    assign alu_use_imm_o = out_q.alu_use_imm;
    assign reg_wb_o      = out_q.reg_wb;
    assign reg_lui_o     = out_q.reg_lui;
    assign is_auipc_o    = out_q.is_auipc;
    assign branch_o      = out_q.branch;
    assign mem_to_reg_o  = out_q.mem_to_reg;
    assign jump_o        = out_q.jump;
    assign mem_type_o    = out_q.mem_type;
    assign word_op_o     = out_q.word_op;
    assign ecall_o       = out_q.ecall;
    assign ebreak_o      = out_q.ebreak;
    assign illegal_o     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: an Xlen=64 and an Xlen=32 instance share stimulus.
// Expectations for ready_o adapt when DECODE_SKID_BUF_EN is defined.

module tb_decode_stage;

`ifdef DECODE_SKID_BUF_EN
    localparam bit Skid = 1'b1;
`else
    localparam bit Skid = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni, flush_i, valid_i, ready_i;
    logic [31:0] instr_i;
    logic [63:0] pc_i;

    logic        ready_o, valid_o, alu_use_imm_o, reg_wb_o, reg_lui_o, is_auipc_o;
    logic        branch_o, mem_to_reg_o, word_op_o, ecall_o, ebreak_o, illegal_o;
    logic [63:0] pc_o, imm_o;
    logic [31:0] instr_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [1:0]  aluop_o, jump_o, mem_type_o;

    logic        ready_32, valid_32, alu_use_imm_32, reg_wb_32, reg_lui_32, is_auipc_32;
    logic        branch_32, mem_to_reg_32, word_op_32, ecall_32, ebreak_32, illegal_32;
    logic [31:0] pc_32, imm_32, instr_32;
    logic [4:0]  rd_32, rs1_32, rs2_32;
    logic [1:0]  aluop_32, jump_32, mem_type_32;

    logic [15:0] flags;
    assign flags = {aluop_o, alu_use_imm_o, reg_wb_o, reg_lui_o, is_auipc_o, branch_o,
                    mem_to_reg_o, jump_o, mem_type_o, word_op_o, ecall_o, ebreak_o, illegal_o};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage #(.Xlen(64)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o),
        .instr_o(instr_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o),
        .aluop_o(aluop_o), .alu_use_imm_o(alu_use_imm_o), .reg_wb_o(reg_wb_o),
        .reg_lui_o(reg_lui_o), .is_auipc_o(is_auipc_o), .branch_o(branch_o),
        .mem_to_reg_o(mem_to_reg_o), .jump_o(jump_o), .mem_type_o(mem_type_o),
        .word_op_o(word_op_o), .ecall_o(ecall_o), .ebreak_o(ebreak_o), .illegal_o(illegal_o)
    );

    decode_stage #(.Xlen(32)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_32),
        .instr_i(instr_i), .pc_i(pc_i[31:0]), .valid_o(valid_32), .ready_i(ready_i), .pc_o(pc_32),
        .instr_o(instr_32), .rd_o(rd_32), .rs1_o(rs1_32), .rs2_o(rs2_32), .imm_o(imm_32),
        .aluop_o(aluop_32), .alu_use_imm_o(alu_use_imm_32), .reg_wb_o(reg_wb_32),
        .reg_lui_o(reg_lui_32), .is_auipc_o(is_auipc_32), .branch_o(branch_32),
        .mem_to_reg_o(mem_to_reg_32), .jump_o(jump_32), .mem_type_o(mem_type_32),
        .word_op_o(word_op_32), .ecall_o(ecall_32), .ebreak_o(ebreak_32), .illegal_o(illegal_32)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [1:0]  aluop;
        logic        ui, wb, lui, auipc, br, m2r;
        logic [1:0]  jump, mem;
        logic        w, ec, eb, ill, ill32;
    } vec_t;

    vec_t tbl [23];

    // Single accepted transfer with ready_i high; outputs are readable on return.
    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b1;
        instr_i = ins;
        pc_i    = pc;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        instr_i = '0; pc_i = '0;
        #12;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        n_checks++; if (imm_o !== 64'h0) begin n_fail++; $display("FAIL reset_imm: got %h expected 0", imm_o); end
        n_checks++; if (pc_o !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc_o); end
        n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instr_o); end
        n_checks++; if (flags !== 16'h0) begin n_fail++; $display("FAIL reset_flags: got %h expected 0", flags); end
        n_checks++; if ({rd_o, rs1_o, rs2_o} !== 15'h0) begin n_fail++; $display("FAIL reset_regs: got %h expected 0", {rd_o, rs1_o, rs2_o}); end
        n_checks++; if ({valid_32, ready_32} !== 2'b01) begin n_fail++; $display("FAIL reset_hs32: got %b expected 01", {valid_32, ready_32}); end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_addi();
        send(32'h0050_0093, 64'h0000_0000_8000_0100);
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b expected 1", valid_o); end
        n_checks++; if (rd_o !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d expected 1", rd_o); end
        n_checks++; if (rs1_o !== 5'd0) begin n_fail++; $display("FAIL addi_rs1: got %0d expected 0", rs1_o); end
        n_checks++; if (imm_o !== 64'd5) begin n_fail++; $display("FAIL addi_imm: got %h expected 5", imm_o); end
        n_checks++; if (aluop_o !== 2'd1) begin n_fail++; $display("FAIL addi_aluop: got %0d expected 1", aluop_o); end
        n_checks++; if (alu_use_imm_o !== 1'b1) begin n_fail++; $display("FAIL addi_use_imm: got %b expected 1", alu_use_imm_o); end
        n_checks++; if (reg_wb_o !== 1'b1) begin n_fail++; $display("FAIL addi_reg_wb: got %b expected 1", reg_wb_o); end
        n_checks++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL addi_illegal: got %b expected 0", illegal_o); end
        n_checks++; if (pc_o !== 64'h0000_0000_8000_0100) begin n_fail++; $display("FAIL addi_pc: got %h expected 80000100", pc_o); end
        n_checks++; if (instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL addi_instr: got %h expected 00500093", instr_o); end
        n_checks++; if (pc_32 !== 32'h8000_0100) begin n_fail++; $display("FAIL addi_pc32: got %h expected 80000100", pc_32); end
    endtask

    task automatic test_word_op();
        send(32'hFFF0_009B, 64'h40);
        n_checks++; if (word_op_o !== 1'b1) begin n_fail++; $display("FAIL addiw64_word_op: got %b expected 1", word_op_o); end
        n_checks++; if (imm_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL addiw64_imm: got %h expected all ones", imm_o); end
        n_checks++; if (illegal_32 !== 1'b1) begin n_fail++; $display("FAIL addiw32_illegal: got %b expected 1", illegal_32); end
        n_checks++; if (reg_wb_32 !== 1'b0) begin n_fail++; $display("FAIL addiw32_reg_wb: got %b expected 0", reg_wb_32); end
        n_checks++; if ({word_op_32, imm_32} !== 33'h0) begin n_fail++; $display("FAIL addiw32_forced: got %h expected 0", {word_op_32, imm_32}); end
        n_checks++; if (instr_32 !== 32'hFFF0_009B) begin n_fail++; $display("FAIL addiw32_instr: got %h expected fff0009b", instr_32); end
    endtask

    task automatic test_decode_table();
        vec_t v;
        logic [15:0] exp_flags;
        // instr, imm, aluop, use_imm, wb, lui, auipc, branch, mem_to_reg, jump, mem, word, ecall, ebreak, ill64, ill32
        tbl = '{
            '{32'h0050_0093, 64'h5,                   2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'hFFF0_009B, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{32'hFFFF_FFFF, 64'h0,                   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{32'h0000_0073, 64'h0,                   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
            '{32'h0010_0073, 64'h0,                   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{32'h0020_0073, 64'h0,                   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{32'h0000_3083, 64'h0,                   2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{32'hFFF1_2083, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'h0000_7083, 64'h0,                   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{32'h0010_3023, 64'h0,                   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{32'h0010_4023, 64'h0,                   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{32'hFE11_2E23, 64'hFFFF_FFFF_FFFF_FFFC, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'hFE00_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'h0000_2063, 64'h0,                   2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{32'h0080_00EF, 64'h8,                   2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'h0041_00E7, 64'h4,                   2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'h0041_10E7, 64'h0,                   2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{32'h8000_00B7, 64'hFFFF_FFFF_8000_0000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'h0000_1097, 64'h1000,                2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'h0FF0_000F, 64'h0,                   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'h0031_00B3, 64'h0,                   2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'h0031_00BB, 64'h0,                   2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
            '{32'h0050_0091, 64'h0,                   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}
        };
        for (int i = 0; i < 23; i++) begin
            v = tbl[i];
            exp_flags = {v.aluop, v.ui, v.wb, v.lui, v.auipc, v.br, v.m2r, v.jump, v.mem, v.w, v.ec, v.eb, v.ill};
            send(v.instr, 64'(i * 4));
            n_checks++; if (imm_o !== v.imm) begin n_fail++; $display("FAIL dec_imm[%h]: got %h expected %h", v.instr, imm_o, v.imm); end
            n_checks++; if (flags !== exp_flags) begin n_fail++; $display("FAIL dec_flags[%h]: got %b expected %b", v.instr, flags, exp_flags); end
            n_checks++; if (illegal_32 !== v.ill32) begin n_fail++; $display("FAIL dec_ill32[%h]: got %b expected %b", v.instr, illegal_32, v.ill32); end
        end
    endtask

    task automatic test_back_to_back();
        int  k = 1, got = 0, occ = 0;
        logic exp_ready;
        @(negedge clk); valid_i = 1'b0; ready_i = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40 && got < 4; cyc++) begin
            @(negedge clk);
            valid_i = (k <= 4);
            instr_i = {12'(k), 5'd0, 3'b000, 5'd1, 7'h13};
            pc_i    = 64'(k);
            ready_i = !(cyc >= 2 && cyc <= 4);
            #1;
            exp_ready = Skid ? (occ < 2) : (occ == 0 || ready_i);
            n_checks++; if (valid_o !== (occ > 0)) begin n_fail++; $display("FAIL b2b_valid cyc%0d: got %b expected %b", cyc, valid_o, occ > 0); end
            n_checks++; if (ready_o !== exp_ready) begin n_fail++; $display("FAIL b2b_ready cyc%0d: got %b expected %b", cyc, ready_o, exp_ready); end
            if (valid_o && ready_i) begin
                n_checks++; if (imm_o !== 64'(got + 1)) begin n_fail++; $display("FAIL b2b_order: got %0d expected %0d", imm_o, got + 1); end
                got++;
                occ--;
            end
            if (valid_i && ready_o) begin
                k++;
                occ++;
            end
            @(posedge clk);
        end
        n_checks++; if (got !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", got); end
        #1;
        valid_i = 1'b0;
    endtask

    task automatic test_flush();
        int n_acc = 0;
        @(negedge clk); valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got %b expected 0", valid_o); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ready_i = 1'b0;
            #1;
            if (!ready_o) break;
            valid_i = 1'b1;
            instr_i = {12'(32 + c), 5'd0, 3'b000, 5'd1, 7'h13};
            n_acc++;
            @(posedge clk);
            #1;
            valid_i = 1'b0;
        end
        n_checks++; if (n_acc !== (Skid ? 2 : 1)) begin n_fail++; $display("FAIL flush_fill: got %0d expected %0d", n_acc, Skid ? 2 : 1); end
        flush_i = 1'b1;
        valid_i = 1'b1;
        instr_i = 32'h0770_0093;
        @(posedge clk); #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", valid_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", ready_o); end
        ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost%0d: got %b expected 0", c, valid_o); end
        end
        send(32'h0090_0093, 64'h900);
        n_checks++; if ({valid_o, imm_o} !== {1'b1, 64'd9}) begin n_fail++; $display("FAIL flush_next: got %b/%h expected 1/9", valid_o, imm_o); end
        @(posedge clk); #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b expected 0", valid_o); end
    endtask

    task automatic test_reset_mid();
        send(32'h0050_0093, 64'h200);
        ready_i = 1'b0;
        @(negedge clk);
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 1", valid_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if ({valid_o, ready_o} !== 2'b01) begin n_fail++; $display("FAIL rstmid_hs: got %b expected 01", {valid_o, ready_o}); end
        n_checks++; if ({pc_o, imm_o, instr_o} !== 160'h0) begin n_fail++; $display("FAIL rstmid_payload: got %h/%h/%h expected 0", pc_o, imm_o, instr_o); end
        n_checks++; if ({flags, rd_o} !== 21'h0) begin n_fail++; $display("FAIL rstmid_ctrl: got %h expected 0", {flags, rd_o}); end
        @(negedge clk);
        rst_ni = 1'b1;
        send(32'h00A0_0093, 64'h300);
        n_checks++; if ({valid_o, imm_o, pc_o} !== {1'b1, 64'd10, 64'h300}) begin n_fail++; $display("FAIL rstmid_resume: got %b/%h/%h expected 1/a/300", valid_o, imm_o, pc_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_word_op();
        test_decode_table();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
